// File: rtl/inv_matrix_loader.sv
// Serial-to-parallel feeder for the 5x5 inverse stage: assembles A (and b when
// INV_LOADER_B_STREAM_EN is defined), holds it stable, times the settle window and flags results.
module inv_matrix_loader #(
  parameter int DW            = 32,
  parameter int N             = 5,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DW-1:0]     in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [N*N*DW-1:0] a_flat,
  output logic [N*N*DW-1:0] b_flat,
  output logic              res_valid,
  input  logic              res_ack,
  output logic              pivot_zero,
  output logic              frame_err
);

  localparam int NN = N * N;
`ifdef INV_LOADER_B_STREAM_EN
  localparam int FRAME_LEN = 2 * NN;
`else
  localparam int FRAME_LEN = NN;
`endif
  localparam int IDX_W = $clog2(FRAME_LEN + 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(FRAME_LEN - 1);
  localparam logic [7:0]       SETTLE_INIT = 8'(SETTLE_CYCLES - 1);

  function automatic logic [NN*DW-1:0] identity_mat();
    logic [NN*DW-1:0] m;
    m = '0;
    for (int r = 0; r < N; r++) begin
      m[(r*N+r)*DW +: DW] = DW'(1);
    end
    return m;
  endfunction

  typedef enum logic [1:0] {LOAD, SETTLE, HOLD} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [7:0]       cnt_q;
  logic             in_ready_q;
  logic             res_valid_q;
  logic             pivot_zero_q;
  logic             frame_err_q;
  logic [NN*DW-1:0] a_q;

  logic accept;
  logic at_last;
  logic frame_bad;

  assign accept    = in_valid && in_ready_q;
  assign at_last   = (idx_q == LAST_IDX);
  // in_last must coincide exactly with the final index of the frame
  assign frame_bad = (in_last != at_last);

`ifdef INV_LOADER_B_STREAM_EN
  logic [NN*DW-1:0] b_q;
  assign b_flat = b_q;
`else
  assign b_flat = identity_mat();
`endif

  assign in_ready   = in_ready_q;
  assign a_flat     = a_q;
  assign res_valid  = res_valid_q;
  assign pivot_zero = pivot_zero_q;
  assign frame_err  = frame_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD;
      idx_q        <= '0;
      cnt_q        <= '0;
      in_ready_q   <= 1'b0;
      res_valid_q  <= 1'b0;
      pivot_zero_q <= 1'b0;
      frame_err_q  <= 1'b0;
      a_q          <= '0;
`ifdef INV_LOADER_B_STREAM_EN
      b_q          <= '0;
`endif
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        LOAD: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            if (frame_bad) begin
              frame_err_q <= 1'b1;
              idx_q       <= '0;
            end else begin
`ifdef INV_LOADER_B_STREAM_EN
              if (int'(idx_q) < NN) begin
                a_q[int'(idx_q)*DW +: DW] <= in_data;
              end else begin
                b_q[(int'(idx_q)-NN)*DW +: DW] <= in_data;
              end
`else
              a_q[int'(idx_q)*DW +: DW] <= in_data;
`endif
              idx_q <= idx_q + IDX_W'(1);
              if (at_last) begin
                // element 0 was written earlier in this frame, so a_q already holds A00
                state_q      <= SETTLE;
                cnt_q        <= SETTLE_INIT;
                in_ready_q   <= 1'b0;
                pivot_zero_q <= (a_q[DW-1:0] == '0);
              end
            end
          end
        end
        SETTLE: begin
          in_ready_q <= 1'b0;
          if (cnt_q == 8'd0) begin
            state_q <= HOLD;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        HOLD: begin
          in_ready_q  <= 1'b0;
          res_valid_q <= 1'b1;
          // an ack is only meaningful once the consumer has seen res_valid
          if (res_ack && res_valid_q) begin
            res_valid_q  <= 1'b0;
            idx_q        <= '0;
            pivot_zero_q <= 1'b0;
            in_ready_q   <= 1'b1;
            state_q      <= LOAD;
          end
        end
        default: begin
          state_q     <= LOAD;
          idx_q       <= '0;
          in_ready_q  <= 1'b0;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_matrix_loader.sv
// Scoreboard bench for inv_matrix_loader: expected matrices are queued when a
// frame completes and compared when res_valid rises.
module tb_inv_matrix_loader;

  localparam int DW = 32;
  localparam int N  = 5;
  localparam int NN = N * N;
  localparam int S  = 8;
`ifdef INV_LOADER_B_STREAM_EN
  localparam int FRAME = 2 * NN;
`else
  localparam int FRAME = NN;
`endif

  logic              clk;
  logic              rst;
  logic [DW-1:0]     in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [NN*DW-1:0]  a_flat;
  logic [NN*DW-1:0]  b_flat;
  logic              res_valid;
  logic              res_ack;
  logic              pivot_zero;
  logic              frame_err;

  inv_matrix_loader #(.DW(DW), .N(N), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .a_flat(a_flat), .b_flat(b_flat), .res_valid(res_valid),
    .res_ack(res_ack), .pivot_zero(pivot_zero), .frame_err(frame_err)
  );

  typedef struct {
    logic [NN*DW-1:0] a;
    logic [NN*DW-1:0] b;
    logic             pz;
  } exp_t;

  exp_t             sb[$];
  int               errors = 0;
  int               checks = 0;
  logic [NN*DW-1:0] model_a;
  logic [NN*DW-1:0] model_b;
  logic [NN*DW-1:0] ident;
  logic [NN*DW-1:0] b_reset;
  int               m_idx;
  logic [31:0]      fr[2*NN];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_model();
    m_idx   = 0;
    model_a = '0;
    model_b = b_reset;
    sb.delete();
  endtask

  task automatic fill_b_ident(input int scale);
    for (int i = NN; i < 2 * NN; i++) fr[i] = (((i - NN) % (N + 1)) == 0) ? 32'(scale) : 32'd0;
  endtask

  task automatic send_elem(input logic [31:0] d, input logic last, input bit gaps);
    bit ok;
    bit err;
    exp_t e;
    if (gaps) begin
      for (int k = 0; k < 4; k++) if ($urandom_range(0, 1) == 1) tick();
    end
    in_data = d; in_valid = 1'b1; in_last = last; ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      if (in_ready === 1'b1) ok = 1'b1;
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
    end else begin
      err = (last != (m_idx == FRAME - 1));
      checks++;
      if (frame_err !== err) begin
        errors++;
        $display("FAIL frame_err idx=%0d: got %b expected %b", m_idx, frame_err, err);
      end
      if (err) begin
        m_idx = 0;
      end else begin
        if (m_idx < NN) model_a[m_idx*DW +: DW] = d;
        else model_b[(m_idx-NN)*DW +: DW] = d;
        if (m_idx == FRAME - 1) begin
          e.a = model_a; e.b = model_b; e.pz = (model_a[DW-1:0] == 32'd0);
          sb.push_back(e);
        end
        m_idx++;
      end
    end
  endtask

  task automatic send_frame(input bit gaps);
    for (int i = 0; i < FRAME; i++) send_elem(fr[i], (i == FRAME - 1), gaps);
  endtask

  task automatic wait_result(output int lat);
    exp_t e;
    bit   rdy_bad;
    lat = -1; rdy_bad = 1'b0;
    for (int c = 1; c <= 60 && lat < 0; c++) begin
      tick();
      if (in_ready !== 1'b0) rdy_bad = 1'b1;
      if (res_valid === 1'b1) lat = c;
    end
    checks++;
    if (rdy_bad) begin
      errors++;
      $display("FAIL in_ready_settle: got 1 expected 0 while waiting for res_valid");
    end
    checks++;
    if (lat < 0) begin
      errors++;
      $display("FAIL res_valid_timeout: res_valid=%b expected 1", res_valid);
    end else if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: res_valid=1 expected no result");
    end else begin
      e = sb.pop_front();
      if (a_flat !== e.a) begin
        errors++;
        $display("FAIL sb_a_flat: got %h expected %h", a_flat[255:0], e.a[255:0]);
      end
      checks++;
      if (b_flat !== e.b) begin
        errors++;
        $display("FAIL sb_b_flat: got %h expected %h", b_flat[255:0], e.b[255:0]);
      end
      checks++;
      if (pivot_zero !== e.pz) begin
        errors++;
        $display("FAIL sb_pivot_zero: got %b expected %b", pivot_zero, e.pz);
      end
    end
  endtask

  task automatic do_ack();
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    m_idx = 0;
    checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1 || pivot_zero !== 1'b0) begin
      errors++;
      $display("FAIL ack: res_valid=%b in_ready=%b pivot_zero=%b expected 0 1 0", res_valid, in_ready, pivot_zero);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; res_ack = 1'b0;
    tick(); tick();
    reset_model();
    checks++;
    if (in_ready !== 1'b0 || res_valid !== 1'b0 || pivot_zero !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: rdy=%b rv=%b pz=%b fe=%b expected all 0", in_ready, res_valid, pivot_zero, frame_err);
    end
    checks++;
    if (a_flat !== model_a || b_flat !== model_b) begin
      errors++;
      $display("FAIL reset_mats: a=%h b=%h expected a=0 b=%h", a_flat[255:0], b_flat[255:0], model_b[255:0]);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b expected 1", in_ready);
    end
  endtask

  task automatic test_basic();
    int lat;
    for (int i = 0; i < NN; i++) fr[i] = 32'(i + 1);
    fill_b_ident(1);
    send_frame(1'b0);
    wait_result(lat);
    checks++;
    if (lat != S + 1) begin
      errors++;
      $display("FAIL latency: got %0d cycles expected %0d", lat, S + 1);
    end
    checks++;
    if (a_flat[0 +: DW] !== 32'd1 || a_flat[24*DW +: DW] !== 32'd25 || b_flat !== ident) begin
      errors++;
      $display("FAIL basic_elems: a00=%0d a44=%0d b_ident=%b expected 1 25 1",
               a_flat[0 +: DW], a_flat[24*DW +: DW], b_flat === ident);
    end
  endtask

  task automatic test_ack_new_frame();
    int lat;
    do_ack();
    for (int i = 0; i < NN; i++) fr[i] = 32'd7;
    fill_b_ident(1);
    send_frame(1'b0);
    wait_result(lat);
    do_ack();
  endtask

  task automatic test_pivot();
    int lat;
    for (int i = 0; i < NN; i++) fr[i] = 32'(i);
    fill_b_ident(1);
    send_frame(1'b0);
    checks++;
    if (pivot_zero !== 1'b1) begin
      errors++;
      $display("FAIL pivot_on_entry: got %b expected 1", pivot_zero);
    end
    wait_result(lat);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (pivot_zero !== 1'b1 || res_valid !== 1'b1) begin
        errors++;
        $display("FAIL pivot_hold: pz=%b rv=%b expected 1 1", pivot_zero, res_valid);
      end
    end
    do_ack();
  endtask

  task automatic test_frame_err();
    int lat;
    for (int i = 0; i < 9; i++) send_elem(32'(100 + i), 1'b0, 1'b0);
    send_elem(32'd999, 1'b1, 1'b0);
    tick();
    checks++;
    if (frame_err !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL frame_err_pulse: fe=%b rdy=%b expected 0 1", frame_err, in_ready);
    end
    checks++;
    if (a_flat !== model_a) begin
      errors++;
      $display("FAIL partial_a: got %h expected %h", a_flat[511:0], model_a[511:0]);
    end
    for (int i = 0; i < FRAME - 1; i++) send_elem(32'(200 + i), 1'b0, 1'b0);
    send_elem(32'd300, 1'b0, 1'b0);
    for (int i = 0; i < NN; i++) fr[i] = 32'(i * 3 + 5);
    fill_b_ident(1);
    send_frame(1'b0);
    wait_result(lat);
    checks++;
    if (lat != S + 1) begin
      errors++;
      $display("FAIL latency_after_err: got %0d expected %0d", lat, S + 1);
    end
    do_ack();
  endtask

  task automatic test_reset_in_settle();
    bit seen;
    for (int i = 0; i < NN; i++) fr[i] = $urandom;
    fill_b_ident(1);
    send_frame(1'b1);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    reset_model();
    checks++;
    if (in_ready !== 1'b0 || res_valid !== 1'b0 || pivot_zero !== 1'b0 || frame_err !== 1'b0
        || a_flat !== model_a || b_flat !== model_b) begin
      errors++;
      $display("FAIL reset_settle: rdy=%b rv=%b pz=%b fe=%b a_zero=%b b_ok=%b expected 0 0 0 0 1 1",
               in_ready, res_valid, pivot_zero, frame_err, a_flat === model_a, b_flat === model_b);
    end
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (res_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL aborted_frame: res_valid_seen=%b in_ready=%b expected 0 1", seen, in_ready);
    end
  endtask

`ifdef INV_LOADER_B_STREAM_EN
  task automatic test_b_stream();
    int lat;
    for (int i = 0; i < NN; i++) fr[i] = 32'(i + 11);
    fill_b_ident(2);
    send_frame(1'b0);
    wait_result(lat);
    for (int i = 0; i < NN; i++) begin
      checks++;
      if (b_flat[i*DW +: DW] !== (((i % (N + 1)) == 0) ? 32'd2 : 32'd0)) begin
        errors++;
        $display("FAIL b_stream elem %0d: got %0d", i, b_flat[i*DW +: DW]);
      end
    end
    do_ack();
    for (int i = 0; i < NN - 1; i++) send_elem(32'(i), 1'b0, 1'b0);
    send_elem(32'd55, 1'b1, 1'b0);
  endtask
`endif

  initial begin
    ident = '0;
    for (int r = 0; r < N; r++) ident[(r*N+r)*DW +: DW] = 32'd1;
`ifdef INV_LOADER_B_STREAM_EN
    b_reset = '0;
`else
    b_reset = ident;
`endif
    test_reset();
    test_basic();
    test_ack_new_frame();
    test_pivot();
    test_frame_err();
    test_reset_in_settle();
`ifdef INV_LOADER_B_STREAM_EN
    test_b_stream();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inv_matrix_loader.md
Name: inv_matrix_loader

Overview:
- Upstream feeder for the combinational 5x5 inverse stage.
- Accepts a serial row-major stream of 32-bit matrix elements through a valid/ready handshake and assembles the A matrix; b defaults to the identity.
- Once the matrix is complete, holds A and b stable on parallel buses for the inverse stage, waits a programmable settle time, then flags the inverse outputs valid until the consumer acknowledges.

Parameters:
- DW, 32, element width; must match the inverse stage datapath.
- N, 5, matrix dimension; fixed at 5 for the current inverse stage; element count N*N = 25.
- SETTLE_CYCLES, 8, cycles A/b are held stable before res_valid asserts; legal range 1..255.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_data  in  DW  serial element, row-major (index = row*N + col)
- in_valid  in  1  in_data valid
- in_last  in  1  marks the final element of a frame
- in_ready  out  1  loader can accept an element this cycle
- a_flat  out  N*N*DW  A matrix; element rc at bits [(r*N+c)*DW +: DW]
- b_flat  out  N*N*DW  b matrix, same packing
- res_valid  out  1  inverse outputs settled and valid
- res_ack  in  1  consumer has taken the inverse outputs
- pivot_zero  out  1  A00 == 0 for the held matrix (inverse invalid)
- frame_err  out  1  one-cycle pulse on framing error

Behaviour:
- Reset values: in_ready=0, res_valid=0, pivot_zero=0, frame_err=0, a_flat=0, b_flat=identity (diagonal DW'd1, rest 0), idx=0, settle counter=0, state=LOAD.
- in_ready rises the first cycle after rst deasserts.
- States: LOAD, SETTLE, HOLD.
- LOAD:
  - in_ready=1.
  - On in_valid&&in_ready, write in_data to A[idx]; idx increments.
  - Accepting idx==24 with in_last=1 -> SETTLE; settle counter = SETTLE_CYCLES-1; pivot_zero = (A00==0), registered with the transition.
  - Framing error: in_last=1 at idx<24, or in_last=0 at idx==24.
    - frame_err pulses for 1 cycle; the element is discarded; idx returns to 0.
    - A keeps its partial contents; stay in LOAD.
- SETTLE:
  - in_ready=0; A/b frozen.
  - Counter decrements each cycle; at 0 -> HOLD.
  - res_valid asserts the cycle after entering HOLD. Latency from last-element acceptance to res_valid = SETTLE_CYCLES+1 cycles.
- HOLD:
  - res_valid=1; A/b frozen; in_ready=0.
  - res_ack=1 -> res_valid=0 next cycle, idx=0, pivot_zero=0, state=LOAD. in_ready=1 that same next cycle.
  - res_ack while not in HOLD is ignored.
- a_flat/b_flat are driven directly from registers, with no glitching outside LOAD writes.
- a_flat changes only on an accepted element write.
- Reset mid-frame or in SETTLE/HOLD: everything returns to reset values next edge; any partial frame is lost.
- in_valid without in_ready: the element is not consumed; upstream holds it.

Optional Feature:
- Macro INV_LOADER_B_STREAM_EN.
- Defined:
  - Frame is 50 elements: A (idx 0..24) then b (idx 25..49), same row-major order; idx is 6 bits.
  - in_last is required at idx 49; in_last at any other index is a framing error.
  - b_flat resets to 0 and keeps its old contents on a framing error.
- Undefined:
  - 25-element frame; b_flat is constant identity; no b write path.

Test Plan:
- Reset, then stream A = 1..25 with in_last on the 25th, SETTLE_CYCLES=8 -> a_flat element 00=1, element 44=25; b_flat = identity; res_valid rises exactly 9 cycles after the last accept; in_ready=0 throughout.
- In HOLD, assert res_ack for 1 cycle -> res_valid=0 and in_ready=1 next cycle; a new frame of all 7s overwrites A; pivot_zero=0.
- Frame with A00=0 -> pivot_zero=1 concurrently with entering SETTLE; it remains 1 until res_ack.
- in_last asserted on the 10th element -> frame_err single-cycle pulse, no transition to SETTLE; a following correct 25-element frame completes normally.
- Random in_valid gaps (50% duty) plus rst asserted in SETTLE -> all outputs at reset values the next cycle; res_valid never asserts for the aborted frame.
- With INV_LOADER_B_STREAM_EN: 50 elements where b = 2*I -> b_flat diagonal = 2, off-diagonal = 0; in_last at idx 24 -> frame_err.
